// File: rtl/sprite_pkg.sv
// Shared types and constants for the knight sprite overlay: pixel struct,
// palette index type and the fixed 16-colour sprite palette.
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [3:0] pal_idx_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam pal_idx_t TRANSPARENT_IDX = 4'd0;

  // Entry 0 is never displayed; it marks see-through sprite pixels.
  localparam rgb_t PALETTE [16] = '{
    24'h000000, 24'h1A1A2E, 24'h5C3A1E, 24'h8B5A2B,
    24'hC0C0C0, 24'hE0E0F0, 24'h7F7F7F, 24'h3F3F3F,
    24'hB22222, 24'hFFD700, 24'h2E8B57, 24'h4169E1,
    24'hF4C2A0, 24'hD2691E, 24'h800080, 24'hFFFFFF
  };

endpackage

// File: rtl/knight_sprite_rom.sv
// Palette-index ROM holding every animation frame back-to-back; one-cycle
// synchronous read.
module knight_sprite_rom
  import sprite_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          vga_clk,
  input  logic [AW-1:0] addr,
  output pal_idx_t      q
);

  // Contents are loaded by the FPGA memory-init flow from knight_sprite.mif.
  (* ram_init_file = "knight_sprite.mif" *) pal_idx_t mem [2**AW];

  always_ff @(posedge vga_clk)
    q <= mem[addr];

endmodule

// File: rtl/knight_sprite_overlay.sv
// Composites the animated knight sprite over the background stream.
// Two-cycle latency from DrawX/DrawY, one from bg_*; position/frame change only at the frame latch.
module knight_sprite_overlay
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int SCALE       = 2,
  parameter int N_FRAMES    = 4,
  parameter int FRAME_TICKS = 6,
  parameter int V_ACTIVE    = 480,
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic          vga_clk,
  input  logic          Reset_n,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          blank,
  input  logic [7:0]    bg_red,
  input  logic [7:0]    bg_green,
  input  logic [7:0]    bg_blue,
  input  logic [9:0]    pos_x,
  input  logic [9:0]    pos_y,
  input  logic          face_left,
  input  logic          anim_en,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic [FW-1:0] frame_idx
);

  localparam int SHIFT = (SCALE == 2) ? 1 : 0;
  localparam int CW    = $clog2(SPR_W);
  localparam int RW    = $clog2(SPR_H);
  localparam int AW    = $clog2(N_FRAMES * SPR_W * SPR_H);
  localparam int TW    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [10:0] SPAN_X = 11'(SPR_W * SCALE);
  localparam logic [10:0] SPAN_Y = 11'(SPR_H * SCALE);

  logic [9:0]    lat_x, lat_y;
  logic          lat_face;
  logic [TW-1:0] tick;
  logic          latch_pt;

  assign latch_pt = (DrawY == 10'(V_ACTIVE)) && (DrawX == 10'd0);

  // Position, facing and animation state only move during vertical blank.
  always_ff @(posedge vga_clk) begin
    if (!Reset_n) begin
      lat_x     <= '0;
      lat_y     <= '0;
      lat_face  <= 1'b0;
      tick      <= '0;
      frame_idx <= '0;
    end else if (latch_pt) begin
      lat_x    <= pos_x;
      lat_y    <= pos_y;
      lat_face <= face_left;
      if (anim_en) begin
        if (tick == TW'(FRAME_TICKS - 1)) begin
          tick      <= '0;
          frame_idx <= (frame_idx == FW'(N_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

  // Stage 0: 11-bit compare so a sprite past the right/bottom edge clips instead of wrapping.
  logic [10:0]   dx, dy, px, py, lx, ly;
  logic          hit;
  logic [CW-1:0] col_raw, col;
  logic [RW-1:0] row;
  logic [AW-1:0] rom_addr;

  assign dx  = {1'b0, DrawX};
  assign dy  = {1'b0, DrawY};
  assign px  = {1'b0, lat_x};
  assign py  = {1'b0, lat_y};
  assign lx  = dx - px;
  assign ly  = dy - py;
  assign hit = (dx >= px) && (dx < px + SPAN_X) && (dy >= py) && (dy < py + SPAN_Y);

  assign col_raw  = CW'(lx >> SHIFT);
  assign col      = lat_face ? CW'(SPR_W - 1) - col_raw : col_raw;
  assign row      = RW'(ly >> SHIFT);
  assign rom_addr = AW'(frame_idx) * AW'(SPR_W * SPR_H) + AW'({row, col});

  pal_idx_t rom_q;

  knight_sprite_rom #(.AW(AW)) u_rom (
    .vga_clk (vga_clk),
    .addr    (rom_addr),
    .q       (rom_q)
  );

  logic blank_d, hit_d;

  always_ff @(posedge vga_clk) begin
    if (!Reset_n) begin
      blank_d <= 1'b0;
      hit_d   <= 1'b0;
    end else begin
      blank_d <= blank;
      hit_d   <= hit;
    end
  end

  // Stage 1: ROM index and background arrive together; pick the pixel.
  rgb_t pix;

  always_comb begin
    pix = '{r: bg_red, g: bg_green, b: bg_blue};
    if (!blank_d)
      pix = '0;
    else if (hit_d && rom_q != TRANSPARENT_IDX)
      pix = PALETTE[rom_q];
  end

  always_ff @(posedge vga_clk) begin
    if (!Reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= pix.r;
      green <= pix.g;
      blue  <= pix.b;
    end
  end

endmodule

// File: tb/tb_knight_sprite_overlay.sv
// Randomized bench for knight_sprite_overlay against a screen-coordinate
// model of the sprite, palette and animation schedule.
module tb_knight_sprite_overlay;

  logic       vga_clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       blank = 1'b0;
  logic [7:0] bg_red = '0, bg_green = '0, bg_blue = '0;
  logic [9:0] pos_x = '0, pos_y = '0;
  logic       face_left = 1'b0, anim_en = 1'b0;
  logic [7:0] red, green, blue;
  logic [1:0] frame_idx;

  always #5 vga_clk = ~vga_clk;

  knight_sprite_overlay dut (
    .vga_clk(vga_clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .pos_x(pos_x), .pos_y(pos_y), .face_left(face_left), .anim_en(anim_en),
    .red(red), .green(green), .blue(blue), .frame_idx(frame_idx)
  );

  int vectors = 0, miscompares = 0;

  logic [23:0] pal [16] = '{
    24'h000000, 24'h1A1A2E, 24'h5C3A1E, 24'h8B5A2B,
    24'hC0C0C0, 24'hE0E0F0, 24'h7F7F7F, 24'h3F3F3F,
    24'hB22222, 24'hFFD700, 24'h2E8B57, 24'h4169E1,
    24'hF4C2A0, 24'hD2691E, 24'h800080, 24'hFFFFFF
  };

  // Reference state: sprite image per frame, latched placement, enabled-latch count.
  logic [3:0]  rom_m [4096];
  int          m_px = 0, m_py = 0, anim_cnt = 0;
  bit          m_face = 0;
  logic [23:0] bg_prev = 24'hFFFFFF;
  logic [23:0] exp_q [$];
  int          xq [$], yq [$];

  function automatic int cur_frame();
    return (anim_cnt / 6) % 4;
  endfunction

  function automatic logic [23:0] model_pix(int x, int y, bit b, logic [23:0] bgv);
    int c, r;
    logic [3:0] idx;
    if (!b) return 24'h0;
    if (x < m_px || x >= m_px + 64 || y < m_py || y >= m_py + 64) return bgv;
    c = (x - m_px) / 2;
    r = (y - m_py) / 2;
    if (m_face) c = 31 - c;
    idx = rom_m[cur_frame() * 1024 + r * 32 + c];
    return (idx == 4'd0) ? bgv : pal[idx];
  endfunction

  function automatic logic [23:0] rnd_bg();
    return 24'($urandom);
  endfunction

  // mode 0: all v; 1: (0,0) clear else 3; 2: col0=1 else 2; 3: frame f = f+1; 4: random
  task automatic rom_write_all(int mode, int v);
    logic [3:0] d;
    for (int i = 0; i < 4096; i++) begin
      case (mode)
        0:       d = 4'(v);
        1:       d = ((i % 1024) == 0) ? 4'd0 : 4'd3;
        2:       d = ((i % 32) == 0) ? 4'd1 : 4'd2;
        3:       d = 4'(i / 1024 + 1);
        default: d = 4'($urandom);
      endcase
      rom_m[i] = d;
      dut.u_rom.mem[i] = d;
    end
  endtask

  // One pixel per cycle; checks the output of the pixel two cycles back.
  task automatic step(int x, int y, bit b, logic [23:0] bgv);
    logic [23:0] got, e;
    int ex, ey;
    @(posedge vga_clk); #1;
    got = {red, green, blue};
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front(); ex = xq.pop_front(); ey = yq.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL pix(%0d,%0d) rgb got %06h exp %06h", ex, ey, got, e);
      end
    end
    vectors++;
    if (frame_idx !== 2'(cur_frame())) begin
      miscompares++;
      $display("FAIL frame_idx got %0d exp %0d", frame_idx, cur_frame());
    end
    {bg_red, bg_green, bg_blue} = bg_prev;
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    exp_q.push_back(model_pix(x, y, b, bgv)); xq.push_back(x); yq.push_back(y);
    bg_prev = bgv;
    if (x == 0 && y == 480) begin
      m_px = int'(pos_x); m_py = int'(pos_y); m_face = face_left;
      if (anim_en) anim_cnt++;
    end
  endtask

  task automatic load_rom(int mode, int v);
    step(700, 0, 0, rnd_bg());
    rom_write_all(mode, v);
  endtask

  task automatic do_latch(int x, int y, bit f, bit a);
    step(700, 480, 0, rnd_bg());
    pos_x = 10'(x); pos_y = 10'(y); face_left = f; anim_en = a;
    step(0, 480, 0, rnd_bg());
  endtask

  task automatic test_reset();
    {bg_red, bg_green, bg_blue} = 24'hFFFFFF;
    Reset_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1 Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge vga_clk); #1;
      DrawX = 10'(10 + i); DrawY = 10'd20; blank = 1'b1;
    end
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk); #1;
      vectors += 2;
      if ({red, green, blue} !== 24'h0) begin
        miscompares++; $display("FAIL reset_rgb[%0d] got %06h exp 000000", i, {red, green, blue});
      end
      if (frame_idx !== 2'd0) begin
        miscompares++; $display("FAIL reset_frame[%0d] got %0d exp 0", i, frame_idx);
      end
      DrawX = DrawX + 10'd1;
    end
    Reset_n = 1'b1;
    @(posedge vga_clk); #1;
    vectors++;
    if ({red, green, blue} !== 24'h0) begin
      miscompares++; $display("FAIL post_reset_black got %06h exp 000000", {red, green, blue});
    end
    DrawX = DrawX + 10'd1;
    @(posedge vga_clk); #1;
    vectors += 2;
    if ({red, green, blue} !== 24'hFFFFFF) begin
      miscompares++; $display("FAIL post_reset_bg got %06h exp FFFFFF", {red, green, blue});
    end
    if (frame_idx !== 2'd0) begin
      miscompares++; $display("FAIL post_reset_frame got %0d exp 0", frame_idx);
    end
    m_px = 0; m_py = 0; m_face = 0; anim_cnt = 0;
    exp_q.delete(); xq.delete(); yq.delete();
    bg_prev = 24'hFFFFFF;
  endtask

  task automatic test_basic();
    load_rom(0, 5);
    do_latch(100, 50, 0, 0);
    step(100, 50, 1, rnd_bg()); step(99, 50, 1, rnd_bg()); step(164, 50, 1, rnd_bg());
    step(163, 113, 1, rnd_bg()); step(163, 114, 1, rnd_bg()); step(100, 49, 1, rnd_bg());
    repeat (100) step(90 + int'($urandom_range(0, 84)), 40 + int'($urandom_range(0, 84)), 1, rnd_bg());
  endtask

  task automatic test_transparent();
    load_rom(1, 0);
    do_latch(200, 100, 0, 0);
    step(200, 100, 1, 24'h123456); step(201, 101, 1, 24'h123456); step(202, 100, 1, 24'h123456);
    repeat (60) step(196 + int'($urandom_range(0, 8)), 96 + int'($urandom_range(0, 8)), 1, rnd_bg());
  endtask

  task automatic test_mirror();
    load_rom(2, 0);
    do_latch(150, 60, 1, 0);
    for (int r = 0; r < 3; r++) begin
      int y;
      y = (r == 2) ? 123 : 60 + r;
      step(212, y, 1, rnd_bg()); step(213, y, 1, rnd_bg());
      step(150, y, 1, rnd_bg()); step(151, y, 1, rnd_bg());
    end
    repeat (60) step(145 + int'($urandom_range(0, 74)), 60 + int'($urandom_range(0, 63)), 1, rnd_bg());
  endtask

  task automatic test_clip();
    load_rom(0, 7);
    do_latch(620, 470, 0, 0);
    for (int y = 470; y < 480; y++)
      for (int x = 0; x < 640; x++)
        if (x <= 50 || x >= 600) step(x, y, 1, rnd_bg());
    for (int y = 0; y < 22; y++)
      for (int x = 0; x < 640; x++)
        if (x <= 43 || x >= 600) step(x, y, 1, rnd_bg());
  endtask

  task automatic test_anim_latch();
    load_rom(3, 0);
    for (int i = 0; i < 30; i++) begin
      do_latch(300, 200, 0, 1);
      step(310, 210, 1, rnd_bg()); step(20, 210, 1, rnd_bg());
    end
    for (int i = 0; i < 5; i++) begin
      do_latch(300, 200, 0, 0);
      step(310, 210, 1, rnd_bg());
    end
    pos_x = 10'd10;
    step(310, 210, 1, rnd_bg()); step(20, 210, 1, rnd_bg()); step(305, 205, 1, rnd_bg());
    do_latch(10, 200, 0, 0);
    step(310, 210, 1, rnd_bg()); step(20, 210, 1, rnd_bg());
  endtask

  task automatic test_random();
    int x, y;
    load_rom(4, 0);
    repeat (6) begin
      do_latch(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      repeat (150) begin
        x = m_px - 8 + int'($urandom_range(0, 80));
        y = m_py - 8 + int'($urandom_range(0, 80));
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        step(x, y, ($urandom_range(0, 7) != 0), rnd_bg());
      end
    end
  endtask

  initial begin
    rom_write_all(0, 0);
    test_reset();
    test_basic();
    test_transparent();
    test_mirror();
    test_clip();
    test_anim_latch();
    test_random();
    step(700, 0, 0, rnd_bg());
    step(700, 0, 0, rnd_bg());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
